cic_osr_ctrl: RTL
=================

# cic_osr_ctrl

Run-time controller for the `cic_decim_osr` decimator. It owns the decimator's `sclr` and `osr` inputs and applies OSR changes safely: hold, flush, then discard the unsettled CIC outputs. It forwards only settled results downstream. It sits between the register/command interface and the ADC decimation chain, one instance per decimator.

## Interface
Parameters:
- `DATA_WIDTH`, 10 — ADC sample width (passed through to decimator).
- `OSR_WIDTH`, 7 — OSR field width; OSR value is stored as ratio minus 1.
- `RES_WIDTH`, `DATA_WIDTH` — decimator result width.
- `OSR_DEFAULT`, 127 — `dec_osr` value after reset.
- `FLUSH_CYCLES`, 4 — clocks `dec_sclr` is held after a (re)start. Legal range is ≥1.
- `SETTLE`, 3 — decimator outputs discarded after flush. Legal range is ≥0.

Ports:
- `clock`  in  1 — single clock.
- `sclr`  in  1 — synchronous reset, active high.
- `enable`  in  1 — run request. Low holds the decimator in reset.
- `osr_req`  in  OSR_WIDTH — requested OSR (ratio−1).
- `osr_load`  in  1 — strobe; applies `osr_req`.
- `dec_res`  in  RES_WIDTH — decimator result.
- `dec_valid`  in  1 — decimator result strobe.
- `dec_sclr`  out  1 — to decimator `sclr`. Registered.
- `dec_osr`  out  OSR_WIDTH — to decimator `osr`. Registered.
- `res`  out  RES_WIDTH — qualified result. Registered.
- `valid`  out  1 — qualified result strobe, 1 cycle.
- `busy`  out  1 — high whenever state ≠ RUN.

## Operation
- States: IDLE, FLUSH, SETTLE, RUN. State is held in a registered FSM.
- Reset values:
  - state = IDLE
  - `dec_sclr` = 1, `dec_osr` = OSR_DEFAULT
  - `res` = 0, `valid` = 0, `busy` = 1
  - flush and settle counters = 0
- IDLE:
  - `dec_sclr` = 1.
  - `enable` = 1 → FLUSH, flush counter cleared.
- FLUSH:
  - `dec_sclr` = 1. Flush counter increments each clock.
  - After FLUSH_CYCLES clocks in FLUSH → SETTLE, with `dec_sclr` = 0 and settle counter cleared.
  - If SETTLE = 0, go to RUN instead.
  - `dec_valid` is ignored.
- SETTLE:
  - Each `dec_valid` increments the settle counter and is dropped (`valid` stays 0).
  - On the SETTLE-th drop → RUN.
- RUN:
  - On `dec_valid`: `res` ← `dec_res` and `valid` ← 1 on the next clock.
  - Otherwise `valid` ← 0. `res` holds its last value.
- `osr_load` = 1 with `enable` = 1, in any state:
  - `dec_osr` ← `osr_req`, state → FLUSH, both counters cleared, `dec_sclr` ← 1.
  - Takes priority over a coincident `dec_valid`; that result is dropped.
  - Reload while already in FLUSH or SETTLE restarts the full FLUSH_CYCLES + SETTLE sequence.
- `osr_load` = 1 with `enable` = 0: `dec_osr` ← `osr_req`, state stays or goes to IDLE.
- `enable` = 0 in any state:
  - Next state IDLE, `dec_sclr` ← 1, `valid` ← 0.
  - Counters are cleared on re-entry to FLUSH.
- Priority, highest first: `sclr`, then `enable` = 0, then `osr_load`, then `dec_valid`.
- Counter widths:
  - Flush counter: $clog2(FLUSH_CYCLES+1).
  - Settle counter: $clog2(SETTLE+1), minimum 1.
  - Neither counter wraps; each saturates at the transition condition.

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- `osr_load` sampled at edge k:
  - `dec_osr` and `dec_sclr` = 1 are visible after edge k.
  - `dec_sclr` stays high for exactly FLUSH_CYCLES clocks, then falls after edge k+FLUSH_CYCLES.
- Start from IDLE (`enable` sampled high at edge k): FLUSH is entered after edge k, and `dec_sclr` falls after edge k+FLUSH_CYCLES.
- Result latency: `dec_valid` sampled in RUN at edge k gives `valid` = 1 and `res` = `dec_res` after edge k, for one cycle only.
- `busy` falls in the same cycle the state becomes RUN.
- `busy` rises on the cycle after `osr_load`, `enable` falling, or `sclr`.
- Back-to-back `dec_valid` in RUN produces back-to-back `valid`.

## Test plan
- Reset release with `enable` = 1 and defaults (OSR 127, FLUSH 4, SETTLE 3):
  - `dec_osr` = 127.
  - `dec_sclr` high for 4 clocks after FLUSH entry.
  - First 3 `dec_valid` dropped; 4th gives `valid` 1 cycle later with `res` = `dec_res`.
  - `busy` falls on RUN entry.
- `osr_load` with `osr_req` = 15 in RUN, coincident with `dec_valid`:
  - `dec_osr` = 15 next cycle.
  - Coincident result dropped.
  - `dec_sclr` high exactly 4 clocks, then 3 results dropped.
- `osr_load` with `osr_req` = 31 in SETTLE after 2 drops:
  - Sequence restarts: 4 flush clocks, then 3 further drops before the first `valid`.
- `enable` dropped in RUN:
  - Next cycle IDLE with `dec_sclr` = 1.
  - Injected `dec_valid` pulses give no `valid`.
  - `enable` restored → 4-clock flush, then 3 drops.
- SETTLE = 0, FLUSH_CYCLES = 1 instance:
  - `dec_sclr` high 1 clock; the first `dec_valid` after it is forwarded.
- `sclr` mid-SETTLE after `osr_load` of 15:
  - `dec_osr` returns to 127, `res` = 0, `valid` = 0, `busy` = 1, state IDLE.

Source files
------------

// File: rtl/cic_osr_ctrl.sv
// cic_osr_ctrl: drives the CIC decimator's sclr/osr, sequencing flush and settle
// after every (re)start so that only settled results reach the output.
module cic_osr_ctrl #(
    parameter int DATA_WIDTH   = 10,
    parameter int OSR_WIDTH    = 7,
    parameter int RES_WIDTH    = DATA_WIDTH,
    parameter int OSR_DEFAULT  = 127,
    parameter int FLUSH_CYCLES = 4,
    parameter int SETTLE       = 3
) (
    input  logic                 clock,
    input  logic                 sclr,
    input  logic                 enable,
    input  logic [OSR_WIDTH-1:0] osr_req,
    input  logic                 osr_load,
    input  logic [RES_WIDTH-1:0] dec_res,
    input  logic                 dec_valid,
    output logic                 dec_sclr,
    output logic [OSR_WIDTH-1:0] dec_osr,
    output logic [RES_WIDTH-1:0] res,
    output logic                 valid,
    output logic                 busy
);
    localparam int FCW = $clog2(FLUSH_CYCLES + 1);
    localparam int SCW = SETTLE > 0 ? $clog2(SETTLE + 1) : 1;
    localparam logic [FCW-1:0] F_LAST = FCW'(FLUSH_CYCLES - 1);
    localparam logic [SCW-1:0] S_LAST = SCW'(SETTLE > 0 ? SETTLE - 1 : 0);
    typedef enum logic [1:0] {ST_IDLE, ST_FLUSH, ST_SETTLE, ST_RUN} state_t;
    state_t               state_q;
    logic [FCW-1:0]       fcnt_q;
    logic [SCW-1:0]       scnt_q;
    logic                 dec_sclr_q;
    logic [OSR_WIDTH-1:0] dec_osr_q;
    logic [RES_WIDTH-1:0] res_q;
    logic                 valid_q;
    logic                 busy_q;
    always_ff @(posedge clock) begin
        if (sclr) begin
            state_q    <= ST_IDLE;
            fcnt_q     <= '0;
            scnt_q     <= '0;
            dec_sclr_q <= 1'b1;
            dec_osr_q  <= OSR_WIDTH'(OSR_DEFAULT);
            res_q      <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            valid_q <= 1'b0;
            if (osr_load) dec_osr_q <= osr_req;
            if (!enable) begin
                state_q    <= ST_IDLE;
                dec_sclr_q <= 1'b1;
                busy_q     <= 1'b1;
            end else if (osr_load || state_q == ST_IDLE) begin
                // A reload restarts the whole flush/settle sequence from scratch
                state_q    <= ST_FLUSH;
                fcnt_q     <= '0;
                scnt_q     <= '0;
                dec_sclr_q <= 1'b1;
                busy_q     <= 1'b1;
            end else begin
                case (state_q)
                    ST_FLUSH: begin
                        fcnt_q <= fcnt_q + FCW'(1);
                        if (fcnt_q == F_LAST) begin
                            dec_sclr_q <= 1'b0;
                            scnt_q     <= '0;
                            state_q    <= SETTLE == 0 ? ST_RUN : ST_SETTLE;
                            busy_q     <= SETTLE != 0;
                        end
                    end
                    ST_SETTLE: if (dec_valid) begin
                        scnt_q <= scnt_q + SCW'(1);
                        if (scnt_q == S_LAST) begin
                            state_q <= ST_RUN;
                            busy_q  <= 1'b0;
                        end
                    end
                    ST_RUN: if (dec_valid) begin
                        res_q   <= dec_res;
                        valid_q <= 1'b1;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end
    assign dec_sclr = dec_sclr_q;
    assign dec_osr  = dec_osr_q;
    assign res      = res_q;
    assign valid    = valid_q;
    assign busy     = busy_q;
endmodule
